axis_window_ctrl: RTL
=====================

# axis_window_ctrl

Sequencer for the 128-bit accumulate-window datapath. It runs a programmed number of windows back to back and programs the window length. It gates the upstream sample-valid into the window block and counts completed windows from the window block's output valid. It sits between the upstream 128-bit sample stream, the window block and the status registers: it configures and sequences the window block and never touches `tdata`.

## Interface
Parameters:
- `CNTR_WIDTH`, default 16: width of the window-count config and of the index counter.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset, synchronous, active-low.
- `cfg_start` in 1: start request, sampled each cycle.
- `cfg_stop` in 1: abort request, sampled each cycle.
- `cfg_length` in 8: window length, latched at start.
- `cfg_count` in CNTR_WIDTH: number of windows to run, latched at start.
- `cfg_gap` in 8: idle cycles between windows, latched at start.
- `s_axis_tvalid` in 1: upstream sample valid.
- `m_axis_tvalid` out 1: gated valid, drives the window block's `s_axis_tvalid`.
- `win_cfg` out 8: window length, drives the window block's `cfg`.
- `win_tvalid` in 1: the window block's `m_axis_tvalid`.
- `sts_index` out CNTR_WIDTH: number of windows completed in the current or last run.
- `sts_busy` out 1: high in any state other than IDLE and DONE.
- `sts_done` out 1: one-cycle pulse when a run finishes normally.

## Operation
States: IDLE, ARM, RUN, GAP, DONE.
- IDLE:
  - Gate closed.
  - `cfg_start` latches `cfg_length` into `win_cfg`, `cfg_count` into the count register and `cfg_gap` into the gap register.
  - `cfg_start` also clears `sts_index` to 0.
  - Next state after start: ARM, or DONE if `cfg_count` is 0.
- ARM:
  - Gate open: `m_axis_tvalid` = `s_axis_tvalid`.
  - First cycle with `s_axis_tvalid` high goes to RUN; that sample passes through the gate.
- RUN:
  - Gate open.
  - `win_tvalid` high increments `sts_index`.
  - If the new index equals the count, go to DONE. Otherwise go to GAP if the gap is nonzero and the gap feature is compiled in; else go to ARM.
- GAP:
  - Gate closed.
  - Down-counter loaded with the latched gap on entry; go to ARM after exactly gap cycles.
- DONE:
  - Gate closed, `sts_done` = 1 for one cycle, then IDLE.
- `cfg_start` is ignored in every state except IDLE.
- `cfg_stop` in ARM, RUN or GAP goes to IDLE next cycle, gate closed, no `sts_done`, `sts_index` holds.
- `cfg_stop` has no effect in IDLE or DONE.
- Simultaneous `cfg_stop` and `win_tvalid` in RUN: stop wins, index not incremented.
- `cfg_length` 0: the window block passes every sample, so each `win_tvalid` counts as one window.
- Index arithmetic is unsigned, CNTR_WIDTH bits. It cannot wrap: a run ends when the index equals the count.
- `win_tvalid` outside RUN is ignored.
- Config inputs changing mid-run have no effect until the next start.

## Timing
- Reset values: state IDLE, `m_axis_tvalid` 0, `win_cfg` 0, `sts_index` 0, `sts_busy` 0, `sts_done` 0, internal counters 0.
- Reset asserted mid-run returns everything to these values on the next edge.
- `m_axis_tvalid` is combinational: `s_axis_tvalid` AND (state is ARM or RUN). It has zero latency.
- `win_cfg` is registered and valid the cycle after start is accepted, i.e. the first ARM cycle.
- `sts_index` updates on the edge after the `win_tvalid` cycle.
- `sts_done` is high in the cycle after the final `win_tvalid`.
- Start to first gated sample: 1 cycle minimum (IDLE, then ARM).
- Start with `cfg_count` 0: `sts_done` the cycle after start, `sts_index` 0.
- `sts_busy` is registered from the state: high from the cycle after start until the cycle DONE is entered.

## Configuration
- `AXIS_WINDOW_CTRL_GAP_EN` defined: GAP state and gap counter are implemented, and `cfg_gap` is honoured.
- Not defined: no GAP state or gap counter. `cfg_gap` is still a port but is ignored, and RUN goes directly to ARM after each non-final window.

## Test plan
- Reset check: apply `aresetn` 0 for 4 cycles with all inputs toggling -> all outputs 0 and `m_axis_tvalid` 0 throughout.
- Normal run: `cfg_length` 4, `cfg_count` 3, `cfg_gap` 0, `s_axis_tvalid` always high, `win_tvalid` modelled 5 cycles after the first gated sample -> `win_cfg` 4; `sts_index` steps 1, 2, 3; single `sts_done` pulse; gate closed after.
- Gap: `cfg_gap` 5 with the macro -> exactly 5 closed-gate cycles between windows. Without the macro -> 0 closed-gate cycles.
- Abort: `cfg_stop` together with the 2nd `win_tvalid` of a 4-window run -> IDLE next cycle, `sts_index` 1, no `sts_done`. A following `cfg_start` restarts from index 0.
- Zero count: `cfg_start` with `cfg_count` 0 -> `sts_done` the next cycle, `m_axis_tvalid` never high.
- Ignored inputs: `cfg_start` pulsed while busy, and `win_tvalid` pulsed in IDLE -> latched configuration, `sts_index` and state unchanged.

Source files
------------

// File: rtl/axis_window_ctrl_if.sv
// Valid/config bundle between the window sequencer, the upstream sample stream and the window block.
// The slave modport is the sequencer side; the master modport is the surrounding environment.
interface axis_window_ctrl_if;
  logic       s_axis_tvalid;
  logic       m_axis_tvalid;
  logic [7:0] win_cfg;
  logic       win_tvalid;

  modport master (
    output s_axis_tvalid,
    output win_tvalid,
    input  m_axis_tvalid,
    input  win_cfg
  );

  modport slave (
    input  s_axis_tvalid,
    input  win_tvalid,
    output m_axis_tvalid,
    output win_cfg
  );
endinterface

// File: rtl/axis_window_ctrl.sv
// Window sequencer: runs cfg_count windows of cfg_length samples, gating upstream valid into the window block.
// Optional inter-window idle gap is compiled in with AXIS_WINDOW_CTRL_GAP_EN.
module axis_window_ctrl #(
  parameter int CNTR_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [7:0]            cfg_length,
  input  logic [CNTR_WIDTH-1:0] cfg_count,
  input  logic [7:0]            cfg_gap,
  axis_window_ctrl_if.slave     axis,
  output logic [CNTR_WIDTH-1:0] sts_index,
  output logic                  sts_busy,
  output logic                  sts_done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_RUN  = 3'd2,
`ifdef AXIS_WINDOW_CTRL_GAP_EN
    ST_GAP  = 3'd3,
`endif
    ST_DONE = 3'd4
  } state_t;

  state_t                state_r;
  logic [7:0]            win_cfg_r;
  logic [CNTR_WIDTH-1:0] count_r;
  logic [CNTR_WIDTH-1:0] index_r;
  logic                  busy_r;
  logic                  done_r;
  logic [CNTR_WIDTH-1:0] index_inc_s;
  logic                  gate_open_s;

`ifdef AXIS_WINDOW_CTRL_GAP_EN
  logic [7:0]            gap_r;
  logic [7:0]            gap_cnt_r;
`else
  logic                  unused_gap_s;
  assign unused_gap_s = ^cfg_gap;
`endif

  assign index_inc_s = index_r + {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
  assign gate_open_s = (state_r == ST_ARM) || (state_r == ST_RUN);

  assign axis.m_axis_tvalid = axis.s_axis_tvalid & gate_open_s;
  assign axis.win_cfg       = win_cfg_r;
  assign sts_index          = index_r;
  assign sts_busy           = busy_r;
  assign sts_done           = done_r;

  // Sequencer FSM; busy/done are registered from the state being entered.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r   <= ST_IDLE;
      win_cfg_r <= 8'd0;
      count_r   <= {CNTR_WIDTH{1'b0}};
      index_r   <= {CNTR_WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef AXIS_WINDOW_CTRL_GAP_EN
      gap_r     <= 8'd0;
      gap_cnt_r <= 8'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (cfg_start) begin
            win_cfg_r <= cfg_length;
            count_r   <= cfg_count;
            index_r   <= {CNTR_WIDTH{1'b0}};
`ifdef AXIS_WINDOW_CTRL_GAP_EN
            gap_r     <= cfg_gap;
`endif
            if (cfg_count == {CNTR_WIDTH{1'b0}}) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_ARM;
              busy_r  <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_ARM: begin
          if (cfg_stop) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (axis.s_axis_tvalid) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_ARM;
          end
        end
        ST_RUN: begin
          // Stop takes priority over a coincident window completion.
          if (cfg_stop) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (axis.win_tvalid) begin
            index_r <= index_inc_s;
            if (index_inc_s == count_r) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
`ifdef AXIS_WINDOW_CTRL_GAP_EN
            else if (gap_r != 8'd0) begin
              state_r   <= ST_GAP;
              gap_cnt_r <= gap_r;
            end
`endif
            else begin
              state_r <= ST_ARM;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
`ifdef AXIS_WINDOW_CTRL_GAP_EN
        ST_GAP: begin
          if (cfg_stop) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            gap_cnt_r <= 8'd0;
          end else if (gap_cnt_r == 8'd1) begin
            state_r   <= ST_ARM;
            gap_cnt_r <= 8'd0;
          end else begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
          end
        end
`endif
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
